// File: rtl/display_source_arbiter_pkg.sv
// display_pkg: the source codes and the arbiter state encoding. They are
// shared with the display driver and the game FSM. The width helper sizes
// the down-counters.
package display_pkg;

  localparam int unsigned VAL_W = 14;

  localparam logic [1:0] SRC_SCORE = 2'd0;
  localparam logic [1:0] SRC_COMBO = 2'd1;
  localparam logic [1:0] SRC_BEST  = 2'd2;

  // State codes match the source codes, so disp_src can be taken straight
  // from the state.
  typedef enum logic [1:0] {
    SHOW_SCORE = 2'd0,
    SHOW_COMBO = 2'd1,
    SHOW_BEST  = 2'd2
  } state_t;

  // Bits needed for a counter that holds 0..n-1. Never returns less than 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_source_arbiter_disp_hold_timer.sv
// disp_hold_timer: a loadable down-counter that saturates at zero.
// Ports:
//   switchClk  clock
//   rst        synchronous active-high reset (count clears to 0)
//   load       load load_val (load wins over dec)
//   load_val   reload value, W bits
//   dec        decrement when the count is nonzero
//   zero       count == 0
module disp_hold_timer
  import display_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 2000,
  parameter int unsigned W         = cnt_width(MAX_COUNT)
) (
  input  logic         switchClk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge switchClk) begin
    if (rst)                     count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/display_source_arbiter.sv
// display_source_arbiter: chooses what the 4-digit score display shows.
// There are three sources, listed from highest to lowest priority:
//   best score while over_req is high > transient combo message > live score.
// All outputs are registered and clamped to MAX_VAL.
// Optional feature: define DISPLAY_ARB_BLINK_EN to make the display blink
// during game over.
// Ports:
//   switchClk   display digit-switch clock
//   rst         synchronous active-high reset
//   score       live game score
//   combo_req   1-cycle pulse that requests display of combo_val
//   combo_val   combo count, sampled only when combo_req is high
//   over_req    game-over level; best_val is shown while it is high
//   best_val    best score
//   disp_value  value sent to the 7-segment driver
//   disp_blank  tells the driver to blank all digits
//   disp_src    current source (SRC_SCORE/SRC_COMBO/SRC_BEST)
//   combo_ack   1-cycle pulse for each accepted combo request
module display_source_arbiter
  import display_pkg::*;
#(
  parameter int unsigned HOLD_TICKS  = 2000,
  parameter int unsigned BLINK_TICKS = 250,
  parameter int unsigned MAX_VAL     = 9999
) (
  input  logic             switchClk,
  input  logic             rst,
  input  logic [VAL_W-1:0] score,
  input  logic             combo_req,
  input  logic [VAL_W-1:0] combo_val,
  input  logic             over_req,
  input  logic [VAL_W-1:0] best_val,
  output logic [VAL_W-1:0] disp_value,
  output logic             disp_blank,
  output logic [1:0]       disp_src,
  output logic             combo_ack
);

  localparam int unsigned HOLD_W = cnt_width(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS - 1);

  function automatic logic [VAL_W-1:0] clamp(input logic [VAL_W-1:0] v);
    return (v > VAL_W'(MAX_VAL)) ? VAL_W'(MAX_VAL) : v;
  endfunction

  state_t           state_q, state_d;
  logic             accept;
  logic             hold_dec, hold_zero;
  logic [VAL_W-1:0] value_d;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      SHOW_SCORE: begin
        if (over_req) state_d = SHOW_BEST;
        else if (combo_req) begin
          accept  = 1'b1;
          state_d = SHOW_COMBO;
        end
      end
      SHOW_COMBO: begin
        if (over_req)       state_d = SHOW_BEST;
        else if (combo_req) accept  = 1'b1;
        else if (hold_zero) state_d = SHOW_SCORE;
      end
      SHOW_BEST: begin
        if (!over_req) state_d = SHOW_SCORE;
      end
      default: state_d = SHOW_SCORE;
    endcase
  end

  // The output register is loaded from the next state. This makes disp_src
  // and disp_value refer to the same source on every cycle. While a combo is
  // held, disp_value keeps its own value, so it acts as the combo latch.
  always_comb begin
    value_d = clamp(score);
    unique case (state_d)
      SHOW_BEST:  value_d = clamp(best_val);
      SHOW_COMBO: value_d = accept ? clamp(combo_val) : disp_value;
      default:    value_d = clamp(score);
    endcase
  end

  assign hold_dec = (state_q == SHOW_COMBO) && (state_d == SHOW_COMBO) && !accept;

  disp_hold_timer #(
    .MAX_COUNT (HOLD_TICKS),
    .W         (HOLD_W)
  ) u_hold (
    .switchClk (switchClk),
    .rst       (rst),
    .load      (accept),
    .load_val  (HOLD_LOAD),
    .dec       (hold_dec),
    .zero      (hold_zero)
  );

  always_ff @(posedge switchClk) begin
    if (rst) begin
      state_q    <= SHOW_SCORE;
      disp_value <= '0;
      disp_src   <= SRC_SCORE;
      combo_ack  <= 1'b0;
    end else begin
      state_q    <= state_d;
      disp_value <= value_d;
      disp_src   <= state_d;
      combo_ack  <= accept;
    end
  end

`ifdef DISPLAY_ARB_BLINK_EN
  localparam int unsigned BLINK_W = cnt_width(BLINK_TICKS);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_TICKS - 1);

  logic in_best, enter_best, blink_zero, blink_load;

  assign in_best    = (state_q == SHOW_BEST) && (state_d == SHOW_BEST);
  assign enter_best = (state_q != SHOW_BEST) && (state_d == SHOW_BEST);
  // The counter restarts on entry and at each half-period boundary. The
  // blank output toggles when the counter reaches zero.
  assign blink_load = enter_best || (in_best && blink_zero);

  disp_hold_timer #(
    .MAX_COUNT (BLINK_TICKS),
    .W         (BLINK_W)
  ) u_blink (
    .switchClk (switchClk),
    .rst       (rst),
    .load      (blink_load),
    .load_val  (BLINK_LOAD),
    .dec       (in_best),
    .zero      (blink_zero)
  );

  always_ff @(posedge switchClk) begin
    if (rst || !in_best) disp_blank <= 1'b0;
    else if (blink_zero) disp_blank <= ~disp_blank;
  end
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^BLINK_TICKS;
  assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_source_arbiter.sv
module tb_display_source_arbiter;

  localparam int HOLD  = 4;
  localparam int BLINK = 3;
  localparam int MAXV  = 9999;
`ifdef DISPLAY_ARB_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        switchClk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] score = '0;
  logic        combo_req = 1'b0;
  logic [13:0] combo_val = '0;
  logic        over_req = 1'b0;
  logic [13:0] best_val = '0;
  logic [13:0] disp_value;
  logic        disp_blank;
  logic [1:0]  disp_src;
  logic        combo_ack;

  display_source_arbiter #(
    .HOLD_TICKS  (HOLD),
    .BLINK_TICKS (BLINK),
    .MAX_VAL     (MAXV)
  ) dut (
    .switchClk  (switchClk),
    .rst        (rst),
    .score      (score),
    .combo_req  (combo_req),
    .combo_val  (combo_val),
    .over_req   (over_req),
    .best_val   (best_val),
    .disp_value (disp_value),
    .disp_blank (disp_blank),
    .disp_src   (disp_src),
    .combo_ack  (combo_ack)
  );

  always #5 switchClk = ~switchClk;

  int total = 0;
  int bad = 0;

  // Behavioural model. src is the source on screen. shown counts the cycles
  // the current combo has been displayed. bestk counts the cycles spent in
  // game over.
  int m_src = 0, m_val = 0, m_blank = 0, m_ack = 0, m_shown = 0, m_bestk = 0;

  function automatic int clampi(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_src = 0; m_val = 0; m_blank = 0; m_ack = 0; m_shown = 0; m_bestk = 0;
    end else if (over_req) begin
      m_bestk = (m_src == 2) ? m_bestk + 1 : 0;
      m_src   = 2;
      m_val   = clampi(int'(best_val));
      m_ack   = 0;
      m_blank = BLINK_ON ? ((m_bestk / BLINK) % 2) : 0;
    end else if (combo_req && m_src != 2) begin
      m_src = 1; m_val = clampi(int'(combo_val)); m_ack = 1; m_shown = 1; m_blank = 0;
    end else if (m_src == 1 && m_shown < HOLD) begin
      m_shown++;
      m_ack = 0;
    end else begin
      m_src = 0; m_val = clampi(int'(score)); m_ack = 0; m_blank = 0;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge switchClk);
    model_edge();
    #1;
    check({tag, ".value"}, int'(disp_value), m_val);
    check({tag, ".src"},   int'(disp_src),   m_src);
    check({tag, ".blank"}, int'(disp_blank), m_blank);
    check({tag, ".ack"},   int'(combo_ack),  m_ack);
  endtask

  initial begin
    // 1: reset with score 123, then release
    score = 14'd123;
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("score_first");
    step("score_hold");

    // 2: single combo, shown for HOLD cycles, then score again
    combo_req = 1'b1; combo_val = 14'd42;
    step("combo_accept");
    combo_req = 1'b0;
    for (int i = 0; i < 6; i++) step("combo_hold");

    // 3: retrigger two cycles into the hold
    combo_req = 1'b1; combo_val = 14'd42;
    step("combo_a");
    combo_req = 1'b0;
    step("combo_a_hold");
    combo_req = 1'b1; combo_val = 14'd43;
    step("combo_retrig");
    combo_req = 1'b0;
    for (int i = 0; i < 6; i++) step("retrig_hold");

    // 4: over and combo together, best value above the clamp ceiling
    over_req = 1'b1; combo_req = 1'b1; combo_val = 14'd7; best_val = 14'd15000;
    step("over_combo");
    combo_req = 1'b0;
    step("over_hold");
    over_req = 1'b0; score = 14'd12000;
    step("over_drop");
    step("score_clamp");

    // 5: over raised mid-combo, then reset mid-combo
    score = 14'd500;
    combo_req = 1'b1; combo_val = 14'd9;
    step("combo_b");
    combo_req = 1'b0;
    step("combo_b_hold");
    over_req = 1'b1; best_val = 14'd777;
    step("over_mid");
    step("over_mid_hold");
    over_req = 1'b0;
    for (int i = 0; i < 5; i++) step("no_resume");
    combo_req = 1'b1; combo_val = 14'd11;
    step("combo_c");
    combo_req = 1'b0;
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    step("after_rst");

    // 6: game over held for 12 cycles, checking the blink pattern
    over_req = 1'b1; best_val = 14'd321;
    for (int i = 0; i < 12; i++) step("blink");
    over_req = 1'b0;
    step("blink_exit");
    step("blink_exit2");

    // Random stimulus, checked against the model
    for (int i = 0; i < 400; i++) begin
      score     = 14'($urandom);
      combo_val = 14'($urandom);
      best_val  = 14'($urandom);
      combo_req = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) over_req = ~over_req;
      rst       = ($urandom_range(0, 99) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
